// File: rtl/output_limit_fifo.sv
// Single-clock FWFT FIFO whose reads can be gated by a host-loaded output-limit counter.
// Define OUTPUT_LIMIT_FIFO_ERR_EN to build the sticky overflow/underflow error flag.
module output_limit_fifo #(
  parameter int D_WIDTH     = 16,
  parameter int A_WIDTH     = 9,
  parameter int LIMIT_WIDTH = 16
) (
  input  logic                   CLK,
  input  logic                   rst,
  input  logic [D_WIDTH-1:0]     din,
  input  logic                   wr_en,
  output logic                   full,
  output logic [D_WIDTH-1:0]     dout,
  input  logic                   rd_en,
  output logic                   empty,
  input  logic                   mode_limit,
  input  logic                   reg_output_limit,
  output logic [LIMIT_WIDTH-1:0] output_limit,
  output logic                   output_limit_not_done,
  output logic [A_WIDTH:0]       count,
  output logic                   err
);

  localparam int DEPTH = 2**A_WIDTH;
  localparam int CW = ((A_WIDTH + 1 > LIMIT_WIDTH) ? A_WIDTH + 1 : LIMIT_WIDTH) + 1;
  localparam logic [CW-1:0] LIM_MAX = {{(CW-LIMIT_WIDTH){1'b0}}, {LIMIT_WIDTH{1'b1}}};
  localparam logic [A_WIDTH:0] FULL_CNT = {1'b1, {A_WIDTH{1'b0}}};

  function automatic logic [LIMIT_WIDTH-1:0] sat_limit(input logic [A_WIDTH:0] v);
    logic [CW-1:0] wide;
    wide = {{(CW-A_WIDTH-1){1'b0}}, v};
    if (wide > LIM_MAX) return {LIMIT_WIDTH{1'b1}};
    return wide[LIMIT_WIDTH-1:0];
  endfunction

  logic [D_WIDTH-1:0]     mem [DEPTH];
  logic [A_WIDTH-1:0]     wr_ptr, rd_ptr;
  logic [A_WIDTH:0]       cnt, mem_words, snap_cnt;
  logic [D_WIDTH-1:0]     dout_p1;
  logic                   vld_p1, mode_q;
  logic [LIMIT_WIDTH-1:0] limit_q, remaining;
  logic                   wr_acc, rd_acc, load;

  assign full      = (cnt == FULL_CNT);
  assign empty     = !vld_p1 | (mode_q & (remaining == '0));
  assign wr_acc    = wr_en & !full;
  assign rd_acc    = rd_en & !empty;
  // Words still in RAM exclude the one already sitting in the output register.
  assign mem_words = cnt - {{A_WIDTH{1'b0}}, vld_p1};
  assign load      = (!vld_p1 | rd_acc) & (mem_words != '0);
  assign snap_cnt  = cnt - {{A_WIDTH{1'b0}}, rd_acc};

  assign dout                  = dout_p1;
  assign count                 = cnt;
  assign output_limit          = limit_q;
  assign output_limit_not_done = (remaining != '0);

  always_ff @(posedge CLK) begin
    if (wr_acc) mem[wr_ptr] <= din;
  end

  // Stage p1: registered RAM read doubles as the fall-through output word.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      dout_p1 <= '0;
      vld_p1  <= 1'b0;
      mode_q  <= 1'b0;
    end else begin
      mode_q <= mode_limit;
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (load) begin
        dout_p1 <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + 1'b1;
      end
      vld_p1 <= load | (vld_p1 & !rd_acc);
      case ({wr_acc, rd_acc})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      limit_q   <= '0;
      remaining <= '0;
    end else if (reg_output_limit) begin
      limit_q   <= sat_limit(snap_cnt);
      remaining <= sat_limit(snap_cnt);
    end else if (mode_q & rd_acc) begin
      remaining <= remaining - 1'b1;
    end
  end

`ifdef OUTPUT_LIMIT_FIFO_ERR_EN
  logic err_q;
  // A gated read in limit mode is normal flow control, so only a truly empty FIFO counts.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else if ((wr_en & full) | (rd_en & !vld_p1 & !mode_q)) err_q <= 1'b1;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: doc/output_limit_fifo.md
Name: output_limit_fifo

Overview:
- Single-clock, parametrised successor to the dual-clock output buffer between the application and the USB high-speed output path.
- Adds configurable data width, depth and limit-counter width, a word-count output, and a sticky error flag.
- Keeps the output-limit mechanism: the host snapshots how many words may leave, and reads stop after exactly that many.
- Sits between an application's dout/wr_en/full interface and the readout logic.

Parameters:
D_WIDTH, 16, data word width in bits
A_WIDTH, 9, address width; depth = 2**A_WIDTH words
LIMIT_WIDTH, 16, width of output_limit and the remaining-words counter

Ports:
CLK  in  1  clock; all logic on rising edge
rst  in  1  asynchronous active-high reset
din  in  D_WIDTH  write data
wr_en  in  1  write request
full  out  1  no free slot
dout  out  D_WIDTH  read data; valid while empty=0 (first-word fall-through)
rd_en  in  1  read request; consumes dout
empty  out  1  no readable word (includes the limit gate)
mode_limit  in  1  1 = reads gated by limit counter; 0 = plain FIFO
reg_output_limit  in  1  one-cycle pulse: snapshot stored count into limit
output_limit  out  LIMIT_WIDTH  last snapshot value
output_limit_not_done  out  1  remaining-words counter nonzero
count  out  A_WIDTH+1  words currently stored
err  out  1  sticky error flag (see Optional Feature)

Behaviour:
- Reset (async, rst=1): pointers=0, count=0, full=0, empty=1, dout=0, output_limit=0, remaining=0, output_limit_not_done=0, err=0. Reset mid-operation discards all stored data.
- Write accepted iff wr_en & !full. Write while full is dropped; no state change except err.
- Read accepted iff rd_en & !empty. Read while empty is ignored; pointers unchanged.
- Latency: a word written at edge N appears on dout with empty=0 after edge N+1 (FIFO was empty, mode_limit=0). After an accepted read, the next word is on dout after the following edge; back-to-back reads sustain 1 word/cycle.
- count is updated every cycle: +1 on accepted write, -1 on accepted read, unchanged when both occur. full = (count == 2**A_WIDTH).
- Limit snapshot on reg_output_limit:
  - snapshot = count minus that cycle's accepted read.
  - A same-cycle write is not included.
  - If the value exceeds 2**LIMIT_WIDTH-1, it saturates to 2**LIMIT_WIDTH-1.
  - The snapshot loads both output_limit and remaining. Loading overrides any same-cycle decrement of remaining.
- mode_limit=1:
  - empty = fifo_empty | (remaining==0).
  - Each accepted read decrements remaining.
  - output_limit_not_done = (remaining != 0).
- mode_limit=0:
  - empty = fifo_empty.
  - remaining is not decremented; output_limit and remaining keep their values.
- mode_limit changes take effect on the next cycle's empty. The data path is never flushed by a mode change.
- Pointers wrap modulo 2**A_WIDTH. Full and empty are distinguished by count, not by pointer equality.
- Storage is inferred block RAM with a registered read plus a one-word output register providing fall-through. No combinational path from rd_en to dout.

Optional Feature:
- Macro: OUTPUT_LIMIT_FIFO_ERR_EN.
- When defined: err is set on the first write while full, or on a read with rd_en=1 while fifo_empty=1 in mode_limit=0. A read with remaining==0 in limit mode does NOT set err. err stays set until rst.
- When undefined: err is tied to 0 and no detection logic is synthesised.

Test Plan:
- Basic: mode_limit=0, write 0x0001..0x0005, then read 5 times -> dout yields 0x0001..0x0005 in order; count 5→0; empty=1 after the 5th read.
- Full/wrap: A_WIDTH=3, write 10 words -> full=1 after the 8th; words 9–10 dropped; with OUTPUT_LIMIT_FIFO_ERR_EN, err=1. Then read 8, write 8, read 8 -> data in order across the wrap.
- Limit: mode_limit=1, write 6 words, pulse reg_output_limit -> output_limit=6, not_done=1. Write 4 more, hold rd_en=1 -> exactly 6 reads; empty=1 with count=4; not_done=0.
- Simultaneous: count=3, reg_output_limit, accepted read and write in the same cycle -> output_limit=2; count stays 3.
- Reset mid-burst: 4 words stored, remaining=4, assert rst asynchronously between edges -> all outputs reset immediately; the next write is visible with empty=0 one cycle later.
- Mode switch: remaining=0 with 3 words stored, set mode_limit=0 -> empty=0 the next cycle and all 3 words readable; output_limit unchanged.
